// File: rtl/serial_addsub_pkg.sv
// Shared constants for the bit-serial add/subtract unit.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_fa_fs_cell.sv
// One-bit full adder / full subtractor cell, reused every cycle by serial_addsub.
module fa_fs_cell
  import serial_addsub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic mode,
  output logic r,
  output logic c_out
);

  logic x;

  // Sum and difference share the same XOR chain; only carry vs borrow differs.
  always_comb begin
    x = a ^ b;
    r = x ^ c;
    if (mode == MODE_SUB) begin
      c_out = (~a & b) | (c & ~x);
    end else begin
      c_out = (a & b) | (c & x);
    end
  end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: one cell, WIDTH cycles per operation, LSB first.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; outputs hold the last completed result
// ST_RUN  | one operand bit per clock through the cell, busy=1
// ST_DONE | single-cycle done pulse; start here chains the next operation
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  // Holds the WIDTH-1 most recent result bits; the final bit joins them on entry to DONE.
  logic [WIDTH-2:0] sh_r;
  logic             mode_q;
  logic             carry_q;
  logic [CW-1:0]    cnt;

  logic             cell_r;
  logic             cell_c;
  logic             accept;
  logic [WIDTH-1:0] r_next;

  fa_fs_cell u_cell (
    .a     (sh_a[0]),
    .b     (sh_b[0]),
    .c     (carry_q),
    .mode  (mode_q),
    .r     (cell_r),
    .c_out (cell_c)
  );

  // A new request is taken only when no operation is in flight.
  always_comb begin
    accept = start && ((state == ST_IDLE) || (state == ST_DONE));
    r_next = {cell_r, sh_r};
  end

  // Sequencing FSM with registered outputs; result/flags load only on the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      sh_a    <= '0;
      sh_b    <= '0;
      sh_r    <= '0;
      mode_q  <= MODE_ADD;
      carry_q <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      state   <= ST_RUN;
      sh_a    <= a;
      sh_b    <= b;
      mode_q  <= mode;
      carry_q <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          sh_a    <= sh_a >> 1;
          sh_b    <= sh_b >> 1;
          sh_r    <= r_next[WIDTH-1:1];
          carry_q <= cell_c;
          cnt     <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            // carry_q still holds the carry/borrow into the MSB at this point.
            result <= r_next;
            cout   <= cell_c;
            ovf    <= carry_q ^ cell_c;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int n_cmp = 0;
  int n_bad = 0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (mode),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic and sign rules.
  task automatic model(input logic m, input logic [W-1:0] av, input logic [W-1:0] bv,
                       output logic [W-1:0] r, output logic co, output logic ov);
    int unsigned ua, ub;
    ua = av;
    ub = bv;
    if (m) begin
      r  = W'(ua - ub);
      co = (ua < ub);
      ov = (av[W-1] != bv[W-1]) && (r[W-1] != av[W-1]);
    end else begin
      r  = W'(ua + ub);
      co = ((ua + ub) >> W) != 0;
      ov = (av[W-1] == bv[W-1]) && (r[W-1] != av[W-1]);
    end
  endtask

  // Issues one request (caller is away from the clock edge) and waits for done.
  // lat counts negedges from the accepting edge until done is seen.
  // poke_at>0 re-asserts start with junk operands at that point of the run.
  task automatic do_op(input logic m, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input int poke_at,
                       output logic [W-1:0] r, output logic co, output logic ov,
                       output int lat, output int busy_cyc, output bit early, output bit tmo);
    logic [W-1:0] r0;
    r0 = result;
    mode = m; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); mode = 1'($urandom);
    lat = 0; busy_cyc = 0; early = 0; tmo = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cyc++;
      if (done) break;
      if (result !== r0) early = 1;
      if (lat == poke_at) begin
        start = 1'b1; a = W'($urandom); b = W'($urandom); mode = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      if (lat > 40) begin
        tmo = 1;
        break;
      end
    end
    start = 1'b0;
    r = result; co = cout; ov = ovf;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, result, cout, ovf} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got busy=%b done=%b result=%h cout=%b ovf=%b, want all 0",
               busy, done, result, cout, ovf);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL post_reset_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_directed(input string nm, input logic m,
                               input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic [W-1:0] er, input logic eco, input logic eov);
    logic [W-1:0] r; logic co, ov; int lat, bc; bit early, tmo;
    logic [W-1:0] mr; logic mco, mov;
    model(m, av, bv, mr, mco, mov);
    do_op(m, av, bv, 0, r, co, ov, lat, bc, early, tmo);
    n_cmp++;
    if (tmo) begin
      n_bad++;
      $display("FAIL %s_timeout: no done within 40 cycles", nm);
    end
    n_cmp++;
    if ({r, co, ov} !== {er, eco, eov} || {mr, mco, mov} !== {er, eco, eov}) begin
      n_bad++;
      $display("FAIL %s: got r=%h c=%b v=%b, want r=%h c=%b v=%b", nm, r, co, ov, er, eco, eov);
    end
    n_cmp++;
    if (lat !== W + 1 || bc !== W) begin
      n_bad++;
      $display("FAIL %s_timing: got latency=%0d busy=%0d, want latency=%0d busy=%0d",
               nm, lat, bc, W + 1, W);
    end
    n_cmp++;
    if (early) begin
      n_bad++;
      $display("FAIL %s_early_result: result changed while running, want held", nm);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_done_width: got done=%b one cycle later, want 0", nm, done);
    end
  endtask

  task automatic test_hold();
    test_directed("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      a = W'($urandom); b = W'($urandom); mode = 1'($urandom);
      @(negedge clk);
      n_cmp++;
      if ({result, cout, ovf, busy, done} !== {8'h7F, 1'b0, 1'b1, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL hold_%0d: got r=%h c=%b v=%b busy=%b done=%b, want r=7f c=0 v=1 idle",
                 i, result, cout, ovf, busy, done);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [W-1:0] r; logic co, ov; int lat, bc; bit early, tmo;
    do_op(1'b0, 8'h33, 8'h44, 3, r, co, ov, lat, bc, early, tmo);
    n_cmp++;
    if (tmo || {r, co, ov} !== {8'h77, 1'b0, 1'b0} || lat !== W + 1) begin
      n_bad++;
      $display("FAIL start_during_run: got r=%h c=%b v=%b lat=%0d tmo=%0d, want r=77 c=0 v=0 lat=%0d",
               r, co, ov, lat, tmo, W + 1);
    end
    // Make sure the poke did not queue a second operation.
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL start_during_run_idle: got busy=%b, want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] r; logic co, ov; int lat, bc; bit early, tmo;
    do_op(1'b1, 8'h05, 8'h09, 0, r, co, ov, lat, bc, early, tmo);
    n_cmp++;
    if (tmo || {r, co, ov} !== {8'hFC, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL b2b_first: got r=%h c=%b v=%b, want r=fc c=1 v=0", r, co, ov);
    end
    // Still inside the done cycle: issue the next request immediately.
    do_op(1'b0, 8'h01, 8'h01, 0, r, co, ov, lat, bc, early, tmo);
    n_cmp++;
    if (tmo || {r, co, ov} !== {8'h02, 1'b0, 1'b0} || lat !== W + 1) begin
      n_bad++;
      $display("FAIL b2b_second: got r=%h c=%b v=%b gap=%0d, want r=02 c=0 v=0 gap=%0d",
               r, co, ov, lat, W + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] r; logic co, ov; int lat, bc; bit early, tmo;
    bit saw_done;
    mode = 1'b0; a = 8'h5A; b = 8'h3C; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, result, cout, ovf} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_run: got busy=%b done=%b r=%h c=%b v=%b, want all 0",
               busy, done, result, cout, ovf);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    n_cmp++;
    if (saw_done) begin
      n_bad++;
      $display("FAIL reset_discard: got activity after reset, want none");
    end
    do_op(1'b0, 8'hC8, 8'h64, 0, r, co, ov, lat, bc, early, tmo);
    n_cmp++;
    if (tmo || {r, co, ov} !== {8'h2C, 1'b1, 1'b0} || lat !== W + 1) begin
      n_bad++;
      $display("FAIL after_reset_op: got r=%h c=%b v=%b lat=%0d, want r=2c c=1 v=0 lat=%0d",
               r, co, ov, lat, W + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [W-1:0] r, av, bv, mr; logic co, ov, m, mco, mov; int lat, bc; bit early, tmo;
    for (int i = 0; i < 40; i++) begin
      av = W'($urandom); bv = W'($urandom); m = 1'($urandom_range(0, 1));
      model(m, av, bv, mr, mco, mov);
      do_op(m, av, bv, 0, r, co, ov, lat, bc, early, tmo);
      n_cmp++;
      if (tmo || {r, co, ov} !== {mr, mco, mov} || lat !== W + 1 || early) begin
        n_bad++;
        $display("FAIL random_%0d: %s %h,%h got r=%h c=%b v=%b lat=%0d, want r=%h c=%b v=%b lat=%0d",
                 i, m ? "sub" : "add", av, bv, r, co, ov, lat, mr, mco, mov, W + 1);
      end
      if (i % 3 == 0) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_directed("add_5a_3c", 1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1);
    test_directed("sub_10_20", 1'b1, 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
    test_directed("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    test_hold();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
